coinc_trigger: RTL
==================

Name: coinc_trigger

Overview:
- Downstream consumer of the per-channel edge_detect outputs. Takes NCH single-cycle, clk-aligned pulses (one per input channel).
- Stretches each pulse into a programmable coincidence window. Fires a one-cycle trigger when at least `majority` channels overlap.
- Enforces a programmable deadtime after each trigger and keeps a saturating trigger scaler for readout.

Parameters:
- NCH, 4, number of input channels
- WIN_W, 4, width of coincidence-window setting
- DEAD_W, 8, width of deadtime setting
- CNT_W, 32, width of trigger scaler
- MAJ_W, $clog2(NCH+1), width of majority setting (derived)

Ports:
- clk  in  1  system clock; same clock as upstream edge_detect
- reset  in  1  asynchronous, active-high reset
- in_pulse  in  NCH  clk-aligned single-cycle pulses, one per channel
- enable  in  1  gates trigger formation only
- window  in  WIN_W  stretch length in clk cycles; 0 treated as 1
- majority  in  MAJ_W  minimum active channels to fire; 0 = never fire
- deadtime  in  DEAD_W  cycles held in DEAD after FIRE
- count_clear  in  1  synchronous scaler clear
- trig_out  out  1  one-cycle trigger pulse
- trig_mask  out  NCH  channels active when trigger formed; held until next fire
- busy  out  1  high in FIRE or DEAD
- trig_count  out  CNT_W  saturating count of triggers

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, all stretch counters 0, state IDLE. Reset mid-operation aborts FIRE/DEAD immediately; there is no pending trigger after release.
- Stretcher per channel:
  - in_pulse[i] high at edge → cnt[i] loads max(window,1).
  - Otherwise cnt[i] decrements if nonzero.
  - active[i] = (cnt[i] != 0).
  - A pulse while active reloads the counter (extends the window, no accumulation).
- Coincidence: hit = enable && majority != 0 && popcount(active) >= majority. majority > NCH never fires.
- State machine (3 states):
  - IDLE: if hit → FIRE.
  - FIRE: lasts 1 cycle. trig_out = 1, trig_mask latched from active, trig_count increments. Then → DEAD if deadtime != 0, else → IDLE.
  - DEAD: down-counter loaded with deadtime on FIRE entry; → IDLE when it reaches 1. Total DEAD cycles equal deadtime. Hits are ignored.
- Latency: pulse sampled at edge n → active during cycle n+1 → trig_out high during cycle n+2. Fixed at 2 cycles.
- Overlap rule: pulses on channels A at edge n and B at edge n+k coincide iff k < max(window,1).
- On the FIRE cycle all stretch counters clear, so the same pulses cannot retrigger. An in_pulse arriving in that same cycle has priority and reloads.
- Sampling of settings:
  - window is sampled at each load.
  - deadtime is sampled at FIRE entry.
  - majority and enable are sampled every IDLE cycle.
  - enable low during DEAD does not shorten DEAD.
- Scaler:
  - Saturates at 2^CNT_W − 1.
  - count_clear → 0.
  - count_clear coincident with FIRE → 1 (clear, then count).
- busy = (state != IDLE), registered with state.

Decomposition:
- Package coinc_pkg:
  - state enum {IDLE, FIRE, DEAD}
  - popcount function parameterised on NCH
- Sub-module pulse_stretcher (one per channel, generate loop):
  - inputs clk, reset, pulse, window, clear
  - output active
  - ~40 lines
- Top module holds the FSM, deadtime counter, mask register and scaler.

Test Plan:
- NCH=4, window=4, majority=2, deadtime=0: pulse ch0 at edge 10, ch1 at edge 13 → trig_out high during cycle 15 only, trig_mask=4'b0011, trig_count=1. Repeat with ch1 at edge 14 → no trigger.
- majority=3, pulses ch0, ch1, ch2 at the same edge → one trigger 2 cycles later, trig_mask=4'b0111. Then majority=0, or majority=5 with all four channels pulsed → no trigger.
- deadtime=5, all four channels pulsed every cycle for 40 cycles → triggers every 7 cycles (FIRE + 5 DEAD + re-stretch), busy high 6 of every 7 cycles, trig_count=6.
- window=0, two channels pulsed 1 cycle apart → no trigger. Same cycle → trigger, confirming window=0 behaves as 1.
- CNT_W=4, force 16 triggers → trig_count stays 15. Assert count_clear in a FIRE cycle → trig_count=1.
- Assert reset during DEAD with stretchers active → all outputs 0 asynchronously. After release, no trig_out until fresh coincident pulses arrive.

Source files
------------

// File: rtl/coinc_pkg.sv
// Shared types and helpers for the coincidence trigger: FSM state encoding
// and a channel popcount used to compare against the majority setting.
package coinc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      DEAD = 2'd2
   } state_t;

   // Counts the set bits among the low n bits of v.
   function automatic int unsigned popcount(input logic [31:0] v, input int unsigned n);
      int unsigned c;
      c = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < n) c = c + {31'b0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle pulse into a window of max(window,1) cycles.
// A new pulse reloads the window; clear drops it unless a pulse arrives.
module pulse_stretcher #(
   parameter int WIN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pulse,
   input  logic [WIN_W-1:0] window,
   input  logic             clear,
   output logic             active
);

   logic [WIN_W-1:0] cnt;
   logic [WIN_W-1:0] load_val;

   assign load_val = (window == '0) ? WIN_W'(1) : window;

   // Pulse has priority over clear so a pulse in the FIRE cycle is not lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (pulse) begin
         cnt <= load_val;
      end else if (clear) begin
         cnt <= '0;
      end else if (cnt != '0) begin
         cnt <= cnt - WIN_W'(1);
      end
   end

   assign active = (cnt != '0);

endmodule

// File: rtl/coinc_trigger.sv
// Majority coincidence trigger: stretched channel windows, one-cycle trigger,
// programmable deadtime and a saturating trigger scaler.
module coinc_trigger
   import coinc_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int WIN_W  = 4,
   parameter int DEAD_W = 8,
   parameter int CNT_W  = 32,
   parameter int MAJ_W  = $clog2(NCH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    in_pulse,
   input  logic              enable,
   input  logic [WIN_W-1:0]  window,
   input  logic [MAJ_W-1:0]  majority,
   input  logic [DEAD_W-1:0] deadtime,
   input  logic              count_clear,
   output logic              trig_out,
   output logic [NCH-1:0]    trig_mask,
   output logic              busy,
   output logic [CNT_W-1:0]  trig_count
);

   state_t            state, next_state;
   logic [NCH-1:0]    active;
   logic [DEAD_W-1:0] dead_cnt;
   int unsigned       pop_cnt;
   logic              hit;

   for (genvar i = 0; i < NCH; i++) begin : g_stretch
      pulse_stretcher #(.WIN_W(WIN_W)) u_stretch (
         .clk    (clk),
         .reset  (reset),
         .pulse  (in_pulse[i]),
         .window (window),
         .clear  (state == FIRE),
         .active (active[i])
      );
   end

   assign pop_cnt = popcount(32'(active), NCH);
   assign hit     = enable && (majority != '0) && (pop_cnt >= 32'(majority));

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (hit) next_state = FIRE;
         FIRE:    next_state = (dead_cnt != '0) ? DEAD : IDLE;
         DEAD:    if (dead_cnt == DEAD_W'(1)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         trig_out <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= next_state;
         trig_out <= (next_state == FIRE);
         busy     <= (next_state != IDLE);
      end
   end

   // Deadtime is captured on FIRE entry; DEAD ends on the cycle it reads 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dead_cnt <= '0;
      end else if (state == IDLE && hit) begin
         dead_cnt <= deadtime;
      end else if (state == DEAD && dead_cnt != '0) begin
         dead_cnt <= dead_cnt - DEAD_W'(1);
      end
   end

   // Mask shows which channels formed the trigger, aligned with trig_out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trig_mask <= '0;
      end else if (state == IDLE && hit) begin
         trig_mask <= active;
      end
   end

   // Scaler counts on the edge closing FIRE, so a clear in that cycle yields 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trig_count <= '0;
      end else if (state == FIRE) begin
         if (count_clear)
            trig_count <= CNT_W'(1);
         else if (trig_count != {CNT_W{1'b1}})
            trig_count <= trig_count + CNT_W'(1);
      end else if (count_clear) begin
         trig_count <= '0;
      end
   end

endmodule
